// File: rtl/cpu_pkg.sv
// Shared pipeline types and constants for destination tracking and hazard detection.
package cpu_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [4:0] rd;
        logic       wren;
        logic       memrd;
    } stage_dst_t;

    localparam stage_dst_t BUBBLE = '{rd: 5'd0, wren: 1'b0, memrd: 1'b0};

    // X31 is hardwired zero, so a write to it is dropped before it can act as a producer.
    function automatic stage_dst_t captureDst(input logic [REG_W-1:0] rd,
                                              input logic wren,
                                              input logic memrd);
        stage_dst_t d;
        d.rd    = rd;
        d.wren  = wren && (rd != ZERO_REG);
        d.memrd = memrd && d.wren;
        return d;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check: a load still in EX cannot forward to the instruction now in ID.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [REG_W-1:0] exRd,
    input  logic             exWren,
    input  logic             exMemrd,
    input  logic [REG_W-1:0] idRn,
    input  logic [REG_W-1:0] idRm,
    input  logic             idUseRn,
    input  logic             idUseRm,
    output logic             stall
);

    logic rnHit;
    logic rmHit;

    // exWren already excludes the zero register, so no separate X31 test is needed.
    assign rnHit = idUseRn && (idRn == exRd);
    assign rmHit = idUseRm && (idRm == exRd);
    assign stall = exMemrd && exWren && (rnHit || rmHit);

endmodule

// File: rtl/dest_track_unit.sv
// Tracks destination/write-enable/load of in-flight instructions through EX, MEM, WB for forwarding.
module dest_track_unit
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wren,
    input  logic             id_memrd,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             flush,
    output logic [REG_W-1:0] ex_rd,
    output logic             ex_wren,
    output logic [REG_W-1:0] mem_rd,
    output logic             mem_wren,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_wren,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_dst_t exReg;
    stage_dst_t memReg;
    stage_dst_t wbReg;
    stage_dst_t exNext;
    logic [CNT_W-1:0] stallCntReg;
    logic [CNT_W-1:0] stallCntNext;

    hazard_detect uHazard (
        .exRd    (exReg.rd),
        .exWren  (exReg.wren),
        .exMemrd (exReg.memrd),
        .idRn    (id_rn),
        .idRm    (id_rm),
        .idUseRn (id_use_rn),
        .idUseRm (id_use_rm),
        .stall   (stall)
    );

    // Flush wins over stall; both inject a bubble into EX.
    always_comb begin
        exNext = captureDst(id_rd, id_wren, id_memrd);
        if (flush || stall) begin
            exNext = BUBBLE;
        end
    end

    always_comb begin
        stallCntNext = stallCntReg;
        if (stall && !flush && (stallCntReg != {CNT_W{1'b1}})) begin
            stallCntNext = stallCntReg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exReg       <= BUBBLE;
            memReg      <= BUBBLE;
            wbReg       <= BUBBLE;
            stallCntReg <= '0;
        end else begin
            exReg       <= exNext;
            memReg      <= exReg;
            wbReg       <= memReg;
            stallCntReg <= stallCntNext;
        end
    end

    assign ex_rd     = exReg.rd;
    assign ex_wren   = exReg.wren;
    assign mem_rd    = memReg.rd;
    assign mem_wren  = memReg.wren;
    assign wb_rd     = wbReg.rd;
    assign wb_wren   = wbReg.wren;
    assign stall_cnt = stallCntReg;

endmodule

// File: tb/tb_dest_track_unit.sv
// Directed bench for dest_track_unit: history-based model checked every cycle plus literal pins.
module tb_dest_track_unit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_wren = 1'b0;
    logic       id_memrd = 1'b0;
    logic [4:0] id_rn = '0;
    logic [4:0] id_rm = '0;
    logic       id_use_rn = 1'b0;
    logic       id_use_rm = 1'b0;
    logic       flush = 1'b0;

    logic [4:0]  ex_rd, mem_rd, wb_rd, sEx_rd, sMem_rd, sWb_rd;
    logic        ex_wren, mem_wren, wb_wren, sEx_wren, sMem_wren, sWb_wren;
    logic        stall, sStall;
    logic [15:0] stall_cnt;
    logic [1:0]  sStall_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dest_track_unit #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .id_rd(id_rd), .id_wren(id_wren), .id_memrd(id_memrd),
        .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .flush(flush),
        .ex_rd(ex_rd), .ex_wren(ex_wren), .mem_rd(mem_rd), .mem_wren(mem_wren),
        .wb_rd(wb_rd), .wb_wren(wb_wren), .stall(stall), .stall_cnt(stall_cnt)
    );

    dest_track_unit #(.CNT_W(2)) dutSmall (
        .clk(clk), .reset_n(reset_n), .id_rd(id_rd), .id_wren(id_wren), .id_memrd(id_memrd),
        .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .flush(flush),
        .ex_rd(sEx_rd), .ex_wren(sEx_wren), .mem_rd(sMem_rd), .mem_wren(sMem_wren),
        .wb_rd(sWb_rd), .wb_wren(sWb_wren), .stall(sStall), .stall_cnt(sStall_cnt)
    );

    // Model: issued[k] is what entered EX on the k-th edge since reset; stage age gives position.
    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } ent_t;

    ent_t issued [0:1023];
    int   nIssued = 0;
    int   stallCount = 0;

    function automatic ent_t stageAt(input int age);
        ent_t e;
        int k;
        e = '0;
        k = nIssued - 1 - age;
        if (k >= 0) e = issued[k % 1024];
        return e;
    endfunction

    function automatic logic modelStall();
        ent_t e;
        e = stageAt(0);
        return e.ld && e.wr && ((id_use_rn && id_rn == e.rd) || (id_use_rm && id_rm == e.rd));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        ent_t e;
        if (!reset_n) begin
            nIssued    <= 0;
            stallCount <= 0;
        end else begin
            e = '0;
            if (!flush && !modelStall()) begin
                e.rd = id_rd;
                e.wr = id_wren && (id_rd != 5'd31);
                e.ld = id_memrd && e.wr;
            end
            issued[nIssued % 1024] <= e;
            nIssued <= nIssued + 1;
            if (modelStall() && !flush) stallCount <= stallCount + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        ent_t e0, e1, e2;
        e0 = stageAt(0);
        e1 = stageAt(1);
        e2 = stageAt(2);
        check("ex_rd", 32'(ex_rd), 32'(e0.rd));
        check("ex_wren", 32'(ex_wren), 32'(e0.wr));
        check("mem_rd", 32'(mem_rd), 32'(e1.rd));
        check("mem_wren", 32'(mem_wren), 32'(e1.wr));
        check("wb_rd", 32'(wb_rd), 32'(e2.rd));
        check("wb_wren", 32'(wb_wren), 32'(e2.wr));
        check("stall", 32'(stall), 32'(modelStall()));
        check("stall_cnt", 32'(stall_cnt), 32'(stallCount > 65535 ? 65535 : stallCount));
        check("small_ex_rd", 32'(sEx_rd), 32'(e0.rd));
        check("small_stall", 32'(sStall), 32'(modelStall()));
        check("small_stall_cnt", 32'(sStall_cnt), 32'(stallCount > 3 ? 3 : stallCount));
        $display("cycle t=%0t ex=%0d/%0d mem=%0d/%0d wb=%0d/%0d stall=%0d cnt=%0d scnt=%0d",
                 $time, ex_rd, ex_wren, mem_rd, mem_wren, wb_rd, wb_wren, stall, stall_cnt, sStall_cnt);
    end

    task automatic drive(input logic [4:0] rd, input logic wr, input logic ld,
                         input logic [4:0] rn, input logic urn,
                         input logic [4:0] rm, input logic urm, input logic fl);
        id_rd = rd; id_wren = wr; id_memrd = ld;
        id_rn = rn; id_use_rn = urn; id_rm = rm; id_use_rm = urm; flush = fl;
    endtask

    task automatic idle();
        drive(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        repeat (2) tick();
        check("rst_ex_wren", 32'(ex_wren), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        reset_n = 1'b1;

        // Pipeline shift of a plain ADD X5
        drive(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
        #1 check("add_stall", 32'(stall), 32'd0);
        tick();
        check("add_ex_rd", 32'(ex_rd), 32'd5);
        check("add_ex_wren", 32'(ex_wren), 32'd1);
        idle();
        tick();
        check("add_mem_rd", 32'(mem_rd), 32'd5);
        tick();
        check("add_wb_rd", 32'(wb_rd), 32'd5);
        check("add_wb_wren", 32'(wb_wren), 32'd1);

        // Load-use: LDUR X3 then ADD X6 reading X3
        drive(5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(5'd6, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        #1 check("lu_stall", 32'(stall), 32'd1);
        tick();
        check("lu_bubble", 32'(ex_wren), 32'd0);
        check("lu_cnt", 32'(stall_cnt), 32'd1);
        check("lu_mem_rd", 32'(mem_rd), 32'd3);
        check("lu_mem_wren", 32'(mem_wren), 32'd1);
        check("lu_stall_gone", 32'(stall), 32'd0);
        tick();
        check("lu_consumer_ex", 32'(ex_rd), 32'd6);

        // Zero register load never produces a hazard
        drive(5'd31, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check("z_ex_wren", 32'(ex_wren), 32'd0);
        drive(5'd8, 1'b1, 1'b0, 5'd31, 1'b1, 5'd0, 1'b0, 1'b0);
        #1 check("z_stall", 32'(stall), 32'd0);
        tick();
        check("z_cnt", 32'(stall_cnt), 32'd1);
        check("z_ex_rd", 32'(ex_rd), 32'd8);

        // Flush outranks a pending load-use stall
        drive(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        #1 check("fl_stall_raw", 32'(stall), 32'd1);
        tick();
        check("fl_ex_wren", 32'(ex_wren), 32'd0);
        check("fl_ex_rd", 32'(ex_rd), 32'd0);
        check("fl_cnt", 32'(stall_cnt), 32'd1);

        // Asynchronous reset mid-operation
        drive(5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check("ar_pre_ex", 32'(ex_rd), 32'd10);
        #1 reset_n = 1'b0;
        #1;
        check("ar_ex_rd", 32'(ex_rd), 32'd0);
        check("ar_mem_wren", 32'(mem_wren), 32'd0);
        check("ar_cnt", 32'(stall_cnt), 32'd0);
        tick();
        reset_n = 1'b1;

        // Six load-use stalls: 2-bit counter saturates at 3
        for (int i = 0; i < 6; i++) begin
            drive(5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            tick();
            drive(5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
            tick();
            tick();
        end
        check("sat_small", 32'(sStall_cnt), 32'd3);
        check("sat_big", 32'(stall_cnt), 32'd6);
        idle();
        tick();
        tick();
        check("sat_hold", 32'(sStall_cnt), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dest_track_unit.md
Name: dest_track_unit

Overview:
- Pipeline-side bookkeeping that feeds the forwarding unit. Tracks destination register, write enable and load flag of in-flight instructions through EX, MEM and WB.
- Drives DestReg1/WrEn1 (EX-stage producer, 1-cycle forward) and DestReg2/WrEn2 (MEM-stage producer, 2-cycle forward) to the forwarding unit.
- Detects load-use hazards that forwarding cannot cover, raises stall and injects bubbles.
- Applies branch flushes and keeps a saturating stall-cycle counter.

Parameters:
REG_W, 5, register index width
ZERO_REG, 31, index of the hardwired zero register (X31); never a valid producer
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
id_rd  input  REG_W  destination register of the instruction in ID
id_wren  input  1  ID instruction writes the register file
id_memrd  input  1  ID instruction is a load
id_rn  input  REG_W  first source register of the ID instruction
id_rm  input  REG_W  second source register of the ID instruction
id_use_rn  input  1  ID instruction reads id_rn
id_use_rm  input  1  ID instruction reads id_rm
flush  input  1  branch taken; squash the ID instruction
ex_rd  output  REG_W  EX-stage destination (DestReg1)
ex_wren  output  1  EX-stage write enable (WrEn1)
mem_rd  output  REG_W  MEM-stage destination (DestReg2)
mem_wren  output  1  MEM-stage write enable (WrEn2)
wb_rd  output  REG_W  WB-stage destination (register file write address)
wb_wren  output  1  WB-stage write enable
stall  output  1  hold PC and IF/ID this cycle
stall_cnt  output  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Reset (reset_n=0, asynchronous):
  - all *_rd = 0, all *_wren = 0, internal ex_memrd = 0, stall_cnt = 0.
  - stall = 0 follows combinationally, because ex_memrd = 0.
  - Reset asserted mid-operation discards all in-flight state immediately.
- Write-enable normalisation at capture: stored wren = id_wren && (id_rd != ZERO_REG). A ZERO_REG destination therefore never appears as a producer downstream.
- stall is combinational, from registered EX state and ID inputs:
  - stall = ex_memrd && ex_wren && ((id_use_rn && id_rn==ex_rd) || (id_use_rm && id_rm==ex_rd)).
  - ex_wren=1 already implies ex_rd != ZERO_REG.
- Every rising edge, when not in reset:
  - wb <= mem and mem <= ex (rd, wren); this shift is unconditional and never stalls.
  - If flush=1, EX <= bubble: rd=0, wren=0, memrd=0. Flush has priority over stall.
  - Else if stall=1, EX <= bubble; the ID instruction is held upstream and re-presented next cycle.
  - Otherwise EX <= {id_rd, normalised wren, id_memrd && normalised wren}.
- Latency: an ID instruction appears on ex_* 1 cycle after capture, mem_* after 2 cycles, wb_* after 3 cycles.
- A load-use hazard costs exactly one stall cycle. After the bubble, the load sits in MEM and the forwarding unit covers it via DestReg2.
- Back-to-back dependent loads each stall once. A load whose destination is ZERO_REG never stalls.
- stall_cnt increments on each clock edge where stall=1 and flush=0. It holds at 2^CNT_W-1 and does not wrap.
- The block has no other state: no FSM beyond the 3-stage shift chain and the counter.

Decomposition:
- Shared package cpu_pkg:
  - REG_W and ZERO_REG constants.
  - typedef struct packed {logic [4:0] rd; logic wren; logic memrd;} stage_dst_t.
  - BUBBLE constant of type stage_dst_t (all zero).
- Sub-module hazard_detect: the purely combinational stall equation. The stage registers and counter stay in dest_track_unit.

Test Plan:
- Reset: drive reset_n=0 while stages hold non-zero values -> all outputs 0 asynchronously, before the next clock edge.
- Pipeline shift: ADD with id_rd=5, id_wren=1 -> ex_rd=5/ex_wren=1 at cycle 1, mem_rd=5 at cycle 2, wb_rd=5 at cycle 3; stall stays 0.
- Load-use: LDUR X3 followed by ADD reading rn=3 -> stall=1 for exactly one cycle, EX bubble (ex_wren=0), stall_cnt=1; next cycle mem_rd=3/mem_wren=1, stall=0.
- Zero register: LDUR with id_rd=31, then consumer with rn=31 -> stall=0, ex_wren=0, stall_cnt unchanged.
- Flush priority: load in EX with rd=7, ID uses rm=7, flush=1 -> EX becomes bubble, stall_cnt not incremented.
- Counter saturation: with CNT_W=2, force 5 stall cycles -> stall_cnt reads 3 and holds.
